bus_demux2: RTL and testbench
=============================

# bus_demux2

One-master-to-two-slave request router for the CPU data bus. It accepts one memory request from the core, decodes the address against two configurable windows, and forwards the request to the matching slave (RAM or peripheral). It then returns that slave's response to the core. It is the fan-out counterpart of the two-input source mux on the core side. It allows one outstanding transaction and generates an error response for unmapped addresses.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- S1_BASE, 32'h0000_0000, slave 1 window base
- S1_MASK, 32'hFFFF_0000, slave 1 match mask; hit when (addr & S1_MASK) == S1_BASE
- S2_BASE, 32'h8000_0000, slave 2 window base
- S2_MASK, 32'hFFFF_F000, slave 2 match mask
- TIMEOUT_CYCLES, 255, response timeout; used only with BUS_DEMUX_TIMEOUT_EN

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- m_req_valid  in  1  master request valid
- m_req_ready  out  1  router can accept a request
- m_addr  in  ADDR_WIDTH  request address
- m_wdata  in  DATA_WIDTH  write data
- m_we  in  1  1 = write, 0 = read
- m_rsp_valid  out  1  one-cycle response pulse to master; no back-pressure
- m_rdata  out  DATA_WIDTH  read data
- m_err  out  1  error flag, qualified by m_rsp_valid
- sN_req_valid  out  1  request to slave N (N = 1, 2)
- sN_req_ready  in  1  slave N accepts request
- sN_addr  out  ADDR_WIDTH  forwarded address
- sN_wdata  out  DATA_WIDTH  forwarded write data
- sN_we  out  1  forwarded write enable
- sN_rsp_valid  in  1  slave N response valid
- sN_rdata  in  DATA_WIDTH  slave N read data

## Operation
- All outputs are registered.
- Reset values: every output is 0, and the state is IDLE.
- m_req_ready rises on the first clk edge after rst_n deasserts.

FSM states: IDLE, REQ, RSP, DONE.
- IDLE (m_req_ready=1). A handshake (m_req_valid & m_req_ready) latches addr, wdata and we, and decodes the target.
  - Slave 1 hit: go to REQ, target 1.
  - Otherwise slave 2 hit: go to REQ, target 2.
  - Neither: go to DONE with error.
  - If both windows hit, slave 1 wins.
- REQ: sN_req_valid=1 for the target only, with latched addr, wdata and we on both slaves' buses. The non-target valid is 0. Hold until sN_req_ready is sampled high, then go to RSP with sN_req_valid=0.
- RSP: wait for the target's sN_rsp_valid.
  - On sample, latch sN_rdata and go to DONE.
  - The non-target's rsp_valid is ignored.
- DONE: m_rsp_valid=1 for exactly one cycle, then IDLE.
  - m_req_ready=0 in DONE, 1 again in IDLE.
  - On error: m_err=1 and m_rdata=0.
  - On write responses: m_rdata carries the slave's rdata unchanged.
- sN_rsp_valid in IDLE, REQ or DONE is ignored.
- m_req_valid outside IDLE is ignored, because ready is low.
- Reset mid-transaction: state returns to IDLE and outputs clear immediately (async). An in-flight slave response arriving later is discarded.

## Timing
- Cycle 0: IDLE handshake.
- Cycle 1: sN_req_valid=1.
- If sN_req_ready is high in cycle 1: cycle 2 is RSP. Earliest slave response is sampled in cycle 2, so m_rsp_valid=1 in cycle 3 and m_req_ready=1 in cycle 4.
- Minimum accept-to-response latency is 3 cycles; back-to-back throughput is one transaction per 4 cycles.
- Unmapped address: m_rsp_valid with m_err in cycle 1; ready again in cycle 2.
- Each cycle of slave stall (low sN_req_ready in REQ, or no sN_rsp_valid in RSP) adds exactly one cycle.

## Configuration
- BUS_DEMUX_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter clears on entry to RSP and increments each cycle in RSP.
  - If it reaches TIMEOUT_CYCLES with no sN_rsp_valid, go to DONE with m_err=1 and m_rdata=0.
  - A response sampled in the same cycle the count is reached wins; no error is flagged.
  - The timeout is not applied in REQ.
- Not defined: no counter is present, and RSP waits indefinitely.

## Test plan
- Read 0x0000_0010, with s1 ready immediately and s1_rsp_valid plus rdata 0xDEADBEEF in the first RSP cycle -> s1_req_valid only in cycle 1; m_rsp_valid in cycle 3 with rdata 0xDEADBEEF and m_err=0; s2_req_valid never high.
- Write 0x8000_0004, wdata 0x12345678, with s2_req_ready held low for 3 cycles -> s2_req_valid high 4 cycles with stable addr, wdata and we=1; m_rsp_valid follows s2_rsp_valid by 1 cycle.
- Read 0x4000_0000 (unmapped) -> no sN_req_valid; m_rsp_valid=1 with m_err=1 and m_rdata=0 in cycle 1; m_req_ready=1 in cycle 2.
- Windows configured to overlap (S2_BASE=0, S2_MASK=S1_MASK), request 0x0000_0020 -> only slave 1 is requested.
- Assert rst_n=0 during RSP, then release, then drive a stray s1_rsp_valid -> all outputs 0 during reset; no m_rsp_valid afterwards; next request completes normally.
- With BUS_DEMUX_TIMEOUT_EN, TIMEOUT_CYCLES=8 and a slave that never responds -> m_rsp_valid with m_err=1 exactly 8 cycles after RSP entry.

Source files
------------

// File: rtl/bus_demux2.sv
// bus_demux2: routes one core request to slave 1 (RAM) or slave 2 (peripheral) by address window; unmapped gets an error.
// Latency: 3 cycles accept-to-response minimum, +1 per slave stall cycle; unmapped addresses respond after 1 cycle.
// Backpressure: one outstanding transaction, m_req_ready low until IDLE; no response throttling. BUS_DEMUX_TIMEOUT_EN bounds the RSP wait.
module bus_demux2 #(
  parameter int unsigned            ADDR_WIDTH     = 32,
  parameter int unsigned            DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]  S1_BASE        = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0]  S1_MASK        = 32'hFFFF_0000,
  parameter logic [ADDR_WIDTH-1:0]  S2_BASE        = 32'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0]  S2_MASK        = 32'hFFFF_F000,
  parameter int unsigned            TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m_req_valid,
  output logic                  m_req_ready,
  input  logic [ADDR_WIDTH-1:0] m_addr,
  input  logic [DATA_WIDTH-1:0] m_wdata,
  input  logic                  m_we,
  output logic                  m_rsp_valid,
  output logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  m_err,
  output logic                  s1_req_valid,
  input  logic                  s1_req_ready,
  output logic [ADDR_WIDTH-1:0] s1_addr,
  output logic [DATA_WIDTH-1:0] s1_wdata,
  output logic                  s1_we,
  input  logic                  s1_rsp_valid,
  input  logic [DATA_WIDTH-1:0] s1_rdata,
  output logic                  s2_req_valid,
  input  logic                  s2_req_ready,
  output logic [ADDR_WIDTH-1:0] s2_addr,
  output logic [DATA_WIDTH-1:0] s2_wdata,
  output logic                  s2_we,
  input  logic                  s2_rsp_valid,
  input  logic [DATA_WIDTH-1:0] s2_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  we;
  } req_t;

  state_t                state_q, state_d;
  req_t                  req_q, req_d;
  logic                  tgt2_q, tgt2_d;   // 1 = slave 2 is the target
  logic                  rdy_d, rsp_vld_d, err_d, s1_vld_d, s2_vld_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  hit1, hit2, hs;
  logic                  tgt_req_ready, tgt_rsp_valid;
  logic [DATA_WIDTH-1:0] tgt_rdata;
  logic                  to_hit;

  assign hit1 = (m_addr & S1_MASK) == S1_BASE;
  assign hit2 = (m_addr & S2_MASK) == S2_BASE;
  assign hs   = m_req_valid & m_req_ready;

  // Only the selected slave's handshake and response are ever looked at.
  assign tgt_req_ready = tgt2_q ? s2_req_ready : s1_req_ready;
  assign tgt_rsp_valid = tgt2_q ? s2_rsp_valid : s1_rsp_valid;
  assign tgt_rdata     = tgt2_q ? s2_rdata     : s1_rdata;

  // Both slave buses carry the latched request; only the valid is steered.
  assign s1_addr  = req_q.addr;
  assign s1_wdata = req_q.wdata;
  assign s1_we    = req_q.we;
  assign s2_addr  = req_q.addr;
  assign s2_wdata = req_q.wdata;
  assign s2_we    = req_q.we;

`ifdef BUS_DEMUX_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] to_cnt;

  // Count cycles spent in RSP; zero on the first RSP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               to_cnt <= '0;
    else if (state_q != RSP)  to_cnt <= '0;
    else                      to_cnt <= to_cnt + 1'b1;
  end

  // Last allowed RSP cycle: a response sampled now still wins.
  assign to_hit = (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  // Next-state and next-output decode; outputs are registered from these.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    tgt2_d  = tgt2_q;
    rdata_d = m_rdata;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          req_d = '{addr: m_addr, wdata: m_wdata, we: m_we};
          if (hit1) begin
            tgt2_d  = 1'b0;
            state_d = REQ;
          end else if (hit2) begin
            tgt2_d  = 1'b1;
            state_d = REQ;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      REQ: begin
        if (tgt_req_ready) state_d = RSP;
      end
      RSP: begin
        if (tgt_rsp_valid) begin
          state_d = DONE;
          rdata_d = tgt_rdata;
        end else if (to_hit) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rdy_d     = (state_d == IDLE);
    rsp_vld_d = (state_d == DONE);
    s1_vld_d  = (state_d == REQ) & ~tgt2_d;
    s2_vld_d  = (state_d == REQ) &  tgt2_d;
  end

  // State, latched request and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      tgt2_q       <= 1'b0;
      m_req_ready  <= 1'b0;
      m_rsp_valid  <= 1'b0;
      m_rdata      <= '0;
      m_err        <= 1'b0;
      s1_req_valid <= 1'b0;
      s2_req_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      tgt2_q       <= tgt2_d;
      m_req_ready  <= rdy_d;
      m_rsp_valid  <= rsp_vld_d;
      m_rdata      <= rdata_d;
      m_err        <= err_d;
      s1_req_valid <= s1_vld_d;
      s2_req_valid <= s2_vld_d;
    end
  end

endmodule

// File: tb/tb_bus_demux2.sv
// tb_bus_demux2: randomized and directed transactions checked against a window-decode/latency reference model.
// Latency: the bench acts as both slaves with programmable request and response stalls.
// Backpressure: slave ready/response timing is driven by the bench; the master side has none.
module tb_bus_demux2;
  localparam logic [31:0] S1_BASE = 32'h0000_0000;
  localparam logic [31:0] S1_MASK = 32'hFFFF_0000;
  localparam logic [31:0] S2_BASE = 32'h8000_0000;
  localparam logic [31:0] S2_MASK = 32'hFFFF_F000;
  localparam int          TO      = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m_req_valid, m_req_ready, m_we, m_rsp_valid, m_err;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        s1_req_valid, s1_req_ready, s1_we, s1_rsp_valid;
  logic [31:0] s1_addr, s1_wdata, s1_rdata;
  logic        s2_req_valid, s2_req_ready, s2_we, s2_rsp_valid;
  logic [31:0] s2_addr, s2_wdata, s2_rdata;

  logic        o_m_req_valid, o_m_req_ready, o_m_rsp_valid, o_m_err;
  logic [31:0] o_m_rdata;
  logic        o_s1_req_valid, o_s1_we, o_s2_req_valid, o_s2_we;
  logic [31:0] o_s1_addr, o_s1_wdata, o_s2_addr, o_s2_wdata;
  logic [31:0] o_m_addr;

  bus_demux2 #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_we(m_we), .m_rsp_valid(m_rsp_valid), .m_rdata(m_rdata), .m_err(m_err),
    .s1_req_valid(s1_req_valid), .s1_req_ready(s1_req_ready), .s1_addr(s1_addr),
    .s1_wdata(s1_wdata), .s1_we(s1_we), .s1_rsp_valid(s1_rsp_valid), .s1_rdata(s1_rdata),
    .s2_req_valid(s2_req_valid), .s2_req_ready(s2_req_ready), .s2_addr(s2_addr),
    .s2_wdata(s2_wdata), .s2_we(s2_we), .s2_rsp_valid(s2_rsp_valid), .s2_rdata(s2_rdata)
  );

  // Overlapping windows: slave 2 window equals slave 1 window.
  bus_demux2 #(.S2_BASE(32'h0000_0000), .S2_MASK(32'hFFFF_0000), .TIMEOUT_CYCLES(TO)) dut_ovl (
    .clk(clk), .rst_n(rst_n),
    .m_req_valid(o_m_req_valid), .m_req_ready(o_m_req_ready), .m_addr(o_m_addr),
    .m_wdata(32'h0), .m_we(1'b0), .m_rsp_valid(o_m_rsp_valid), .m_rdata(o_m_rdata), .m_err(o_m_err),
    .s1_req_valid(o_s1_req_valid), .s1_req_ready(1'b1), .s1_addr(o_s1_addr),
    .s1_wdata(o_s1_wdata), .s1_we(o_s1_we), .s1_rsp_valid(1'b1), .s1_rdata(32'h1111_1111),
    .s2_req_valid(o_s2_req_valid), .s2_req_ready(1'b1), .s2_addr(o_s2_addr),
    .s2_wdata(o_s2_wdata), .s2_we(o_s2_we), .s2_rsp_valid(1'b1), .s2_rdata(32'h2222_2222)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic clear_slaves();
    s1_req_ready = 1'b0; s1_rsp_valid = 1'b0;
    s2_req_ready = 1'b0; s2_rsp_valid = 1'b0;
  endtask

  // One transaction: a = request stall cycles, b = cycles between acceptance+1 and response.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                         input logic [31:0] rdata, input int a, input int b, input bit noise);
    bit          hit1, hit2;
    int          tgt, exp_lat, n1, n2, acc, rsp_c, c;
    bit          exp_err, stable, rdy_low;
    logic [31:0] exp_rd, got_rd;
    logic        got_err;
    hit1 = (addr & S1_MASK) == S1_BASE;
    hit2 = (addr & S2_MASK) == S2_BASE;
    tgt  = hit1 ? 1 : (hit2 ? 2 : 0);
    if (tgt == 0) begin
      exp_lat = 1; exp_err = 1'b1; exp_rd = 32'h0;
    end else begin
      exp_lat = 3 + a + b; exp_err = 1'b0; exp_rd = rdata;
`ifdef BUS_DEMUX_TIMEOUT_EN
      if (b >= TO) begin
        exp_lat = 2 + a + TO; exp_err = 1'b1; exp_rd = 32'h0;
      end
`endif
    end
    n1 = 0; n2 = 0; acc = -1; rsp_c = -1; stable = 1'b1; rdy_low = 1'b1;
    got_err = 1'b0; got_rd = 32'h0;

    c = 0;
    while (!m_req_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("ready_before_req", m_req_ready, 1);
    m_req_valid = 1'b1; m_addr = addr; m_wdata = wdata; m_we = we;

    for (c = 1; c <= 80; c++) begin
      @(negedge clk);
      m_req_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        m_addr = $urandom; m_wdata = $urandom; m_we = 1'($urandom_range(0, 1));
      end
      if (s1_req_valid) n1++;
      if (s2_req_valid) n2++;
      if ((s1_req_valid || s2_req_valid) &&
          (s1_addr !== addr || s2_addr !== addr || s1_wdata !== wdata ||
           s2_wdata !== wdata || s1_we !== we || s2_we !== we)) stable = 1'b0;
      if (m_req_ready) rdy_low = 1'b0;
      clear_slaves();
      if (m_rsp_valid) begin
        rsp_c = c; got_err = m_err; got_rd = m_rdata;
        break;
      end
      if (tgt == 1 && s1_req_valid && n1 == a + 1) begin s1_req_ready = 1'b1; acc = c; end
      if (tgt == 2 && s2_req_valid && n2 == a + 1) begin s2_req_ready = 1'b1; acc = c; end
      if (acc > 0 && c == acc + 1 + b) begin
        if (tgt == 1) begin s1_rsp_valid = 1'b1; s1_rdata = rdata; end
        else          begin s2_rsp_valid = 1'b1; s2_rdata = rdata; end
      end
      if (noise) begin
        // Stray activity on the non-target slave, and target responses before acceptance.
        if (tgt != 1 && !s1_req_valid) begin
          s1_rsp_valid = 1'($urandom_range(0, 1)); s1_req_ready = 1'($urandom_range(0, 1)); s1_rdata = $urandom;
        end
        if (tgt != 2 && !s2_req_valid) begin
          s2_rsp_valid = 1'($urandom_range(0, 1)); s2_req_ready = 1'($urandom_range(0, 1)); s2_rdata = $urandom;
        end
        if (acc < 0 && tgt == 1 && !s1_req_ready) s1_rsp_valid = 1'($urandom_range(0, 1));
        if (acc < 0 && tgt == 2 && !s2_req_ready) s2_rsp_valid = 1'($urandom_range(0, 1));
      end
    end
    m_req_valid = 1'b0;
    clear_slaves();

    chk("rsp_cycle", rsp_c, exp_lat);
    chk("rsp_err", got_err, exp_err);
    chk("rsp_rdata", got_rd, exp_rd);
    chk("s1_req_cycles", n1, (tgt == 1) ? a + 1 : 0);
    chk("s2_req_cycles", n2, (tgt == 2) ? a + 1 : 0);
    chk("req_fields_stable", stable, 1);
    chk("ready_low_while_busy", rdy_low, 1);
    @(negedge clk);
    chk("rsp_single_pulse", m_rsp_valid, 0);
    chk("ready_back", m_req_ready, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cls, n1, n2, nr;
    logic [31:0] a, rd;
    m_req_valid = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_we = 1'b0;
    s1_rdata = 32'h0; s2_rdata = 32'h0;
    clear_slaves();
    o_m_req_valid = 1'b0; o_m_addr = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst_ctl", {m_req_ready, m_rsp_valid, m_err, s1_req_valid, s2_req_valid, s1_we, s2_we}, 0);
    chk("rst_rdata", m_rdata, 0);
    chk("rst_bus1", {s1_addr, s1_wdata}, 0);
    chk("rst_bus2", {s2_addr, s2_wdata}, 0);
    rst_n = 1'b1;
    #1 chk("ready_low_before_edge", m_req_ready, 0);
    @(negedge clk);
    chk("ready_after_reset", m_req_ready, 1);

    // Directed cases.
    run_txn(32'h0000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF, 0, 0, 1'b0);
    run_txn(32'h8000_0004, 32'h1234_5678, 1'b1, 32'hCAFE_0001, 3, 0, 1'b0);
    run_txn(32'h4000_0000, 32'h0, 1'b0, 32'h0000_0055, 0, 0, 1'b0);
    run_txn(32'h0000_FFFC, 32'hA5A5_5A5A, 1'b1, 32'h0BAD_F00D, 1, 2, 1'b0);

    // Reset during RSP, then a stray slave response.
    m_req_valid = 1'b1; m_addr = 32'h0000_0100; m_wdata = 32'h77; m_we = 1'b0;
    @(negedge clk);
    m_req_valid = 1'b0; s1_req_ready = 1'b1;
    @(negedge clk);
    s1_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ctl", {m_req_ready, m_rsp_valid, m_err, s1_req_valid, s2_req_valid, s1_we, s2_we}, 0);
    chk("midrst_bus", {s1_addr, m_rdata}, 0);
    @(negedge clk);
    rst_n = 1'b1; s1_rsp_valid = 1'b1; s1_rdata = 32'h5555_AAAA;
    nr = 0; n1 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m_rsp_valid) nr++;
      if (s1_req_valid || s2_req_valid) n1++;
    end
    s1_rsp_valid = 1'b0;
    chk("stray_rsp_ignored", nr, 0);
    chk("stray_no_req", n1, 0);
    run_txn(32'h0000_0200, 32'h0, 1'b0, 32'h1357_9BDF, 0, 1, 1'b0);

`ifdef BUS_DEMUX_TIMEOUT_EN
    run_txn(32'h0000_0020, 32'h0, 1'b0, 32'h0, 1, TO + 20, 1'b0);
    run_txn(32'h8000_0020, 32'h0, 1'b0, 32'h2468_ACE0, 0, TO - 1, 1'b0);
`endif

    // Overlapping windows on the second instance: slave 1 must win.
    o_m_addr = 32'h0000_0020; o_m_req_valid = 1'b1;
    n1 = 0; n2 = 0; nr = 0; rd = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      o_m_req_valid = 1'b0;
      if (o_s1_req_valid) n1++;
      if (o_s2_req_valid) n2++;
      if (o_m_rsp_valid) begin nr++; rd = o_m_rdata; end
    end
    chk("ovl_s1_req", n1, 1);
    chk("ovl_s2_req", n2, 0);
    chk("ovl_rsp_count", nr, 1);
    chk("ovl_rdata", rd, 32'h1111_1111);

    // Randomized transactions with stray traffic.
    for (int t = 0; t < 40; t++) begin
      cls = $urandom_range(0, 3);
      case (cls)
        0:       a = {16'h0000, 16'($urandom)};
        1:       a = 32'h8000_0000 | {20'h0, 12'($urandom)};
        2:       a = 32'h8000_1000 | {20'h0, 12'($urandom)};
        default: a = $urandom;
      endcase
      run_txn(a, $urandom, 1'($urandom_range(0, 1)), $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
